// File: rtl/gpio_expander_pkg.sv
// Shared constants for the SPI GPIO expander: widths, frame layout,
// register indices and bank select codes.
package gpio_expander_pkg;

  localparam int BANK_NUM    = 2;
  localparam int DATA_WIDTH  = 16;
  localparam int PDATA_WIDTH = 8;
  localparam int ADDR_WIDTH  = 7;
  localparam int PADDR_WIDTH = 3;
  localparam int CNT_WIDTH   = 5;

  // Frame field positions, bit 15 is shifted in first
  localparam int W_BIT     = 15;
  localparam int ADDR_MSB  = 14;
  localparam int ADDR_LSB  = 8;
  localparam int DATA_MSB  = 7;
  localparam int DATA_LSB  = 0;

  // Per-bank register index (addr[4:2])
  typedef enum logic [PADDR_WIDTH-1:0] {
    REG_DIR  = 3'd0,
    REG_OUT  = 3'd1,
    REG_IN   = 3'd2,
    REG_SET  = 3'd3,
    REG_CLR  = 3'd4,
    REG_RSV5 = 3'd5,
    REG_TGL  = 3'd6,
    REG_RSV7 = 3'd7
  } reg_idx_e;

  // Bank select codes (addr[6:5])
  typedef enum logic [1:0] {
    SEL_NONE0 = 2'b00,
    SEL_BANK0 = 2'b01,
    SEL_BANK1 = 2'b10,
    SEL_NONE3 = 2'b11
  } bank_sel_e;

  // Select code that addresses bank b (bank0 -> 01, bank1 -> 10)
  function automatic logic [1:0] bank_code(input int unsigned b);
    return 2'(b + 32'd1);
  endfunction

endpackage

// File: rtl/gpio_bank.sv
// One 8-pin GPIO bank: DIR/OUT registers, bit-op updates, read mux and
// pad tristate drivers.
module gpio_bank
  import gpio_expander_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [PADDR_WIDTH-1:0] wr_idx,
  input  logic [PDATA_WIDTH-1:0] wr_data,
  input  logic [PADDR_WIDTH-1:0] rd_idx,
  output logic [PDATA_WIDTH-1:0] rd_data,
  inout  wire  [PDATA_WIDTH-1:0] pad
);

  logic [PDATA_WIDTH-1:0] dir_r;
  logic [PDATA_WIDTH-1:0] out_r;

  // Register updates: plain writes to DIR/OUT, read-modify-write bit ops on OUT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_r <= 8'h00;
      out_r <= 8'h00;
    end else if (wr_en) begin
      case (wr_idx)
        REG_DIR: dir_r <= wr_data;
        REG_OUT: out_r <= wr_data;
        REG_SET: out_r <= out_r | wr_data;
        REG_CLR: out_r <= out_r & ~wr_data;
        REG_TGL: out_r <= out_r ^ wr_data;
        default: begin
          dir_r <= dir_r;
          out_r <= out_r;
        end
      endcase
    end else begin
      dir_r <= dir_r;
      out_r <= out_r;
    end
  end

  // Read mux; IN returns raw pad levels (output pads read their own drive)
  always_comb begin
    rd_data = 8'h00;
    case (rd_idx)
      REG_DIR: rd_data = dir_r;
      REG_OUT: rd_data = out_r;
      REG_IN:  rd_data = pad;
      default: rd_data = 8'h00;
    endcase
  end

  for (genvar i = 0; i < PDATA_WIDTH; i++) begin : g_pad
    assign pad[i] = dir_r[i] ? out_r[i] : 1'bz;
  end

endmodule

// File: rtl/gpio_expander.sv
// SPI mode-0 slave front end: 16-bit frame shifter, bit counter, address
// decode and miso tx shifter, feeding BANK_NUM GPIO banks.
module gpio_expander
  import gpio_expander_pkg::*;
(
  input  logic                             sclk,
  input  logic                             resetn,
  input  logic                             ss,
  input  logic                             mosi,
  output logic                             miso,
  inout  wire  [BANK_NUM*PDATA_WIDTH-1:0]  pad
);

  logic [CNT_WIDTH-1:0]   bit_cnt_r;
  logic [DATA_WIDTH-2:0]  rx_shift_r;
  logic [PDATA_WIDTH-1:0] tx_shift_r;

  logic [DATA_WIDTH-1:0]  frame_s;
  logic                   wr_commit_s;
  logic [1:0]             wr_sel_s;
  logic [1:0]             rd_sel_s;
  logic [PADDR_WIDTH-1:0] wr_idx_s;
  logic [PADDR_WIDTH-1:0] rd_idx_s;
  logic [PDATA_WIDTH-1:0] wr_data_s;
  logic [PDATA_WIDTH-1:0] rd_mux_s;
  logic [PDATA_WIDTH-1:0] rd_word_s;
  logic [BANK_NUM-1:0]    bank_wr_s;
  logic [PDATA_WIDTH-1:0] bank_rd_s [BANK_NUM];
  logic                   unused_s;

  // Full frame as seen on the 16th rising edge: 15 stored bits plus live mosi
  assign frame_s     = {rx_shift_r, mosi};
  assign wr_commit_s = !ss && (bit_cnt_r == 5'd15) && frame_s[W_BIT];
  assign wr_sel_s    = frame_s[ADDR_MSB -: 2];
  assign wr_idx_s    = frame_s[ADDR_MSB-2 -: PADDR_WIDTH];
  assign wr_data_s   = frame_s[DATA_MSB:DATA_LSB];
  assign unused_s    = ^frame_s[ADDR_LSB+1:ADDR_LSB];

  // After 8 rising edges the W bit and address sit in rx_shift_r[7:0]
  assign rd_sel_s = rx_shift_r[6:5];
  assign rd_idx_s = rx_shift_r[4:2];

  // Receive shifter and bit counter; ss high aborts the frame asynchronously
  always_ff @(posedge sclk or negedge resetn or posedge ss) begin
    if (!resetn) begin
      bit_cnt_r  <= 5'd0;
      rx_shift_r <= 15'h0000;
    end else if (ss) begin
      bit_cnt_r  <= 5'd0;
      rx_shift_r <= 15'h0000;
    end else if (bit_cnt_r != 5'd16) begin
      bit_cnt_r  <= bit_cnt_r + 5'd1;
      rx_shift_r <= {rx_shift_r[DATA_WIDTH-3:0], mosi};
    end else begin
      bit_cnt_r  <= bit_cnt_r;
      rx_shift_r <= rx_shift_r;
    end
  end

  // Bank read data OR-combined by select match; unmapped selects read zero
  always_comb begin
    rd_mux_s = 8'h00;
    for (int b = 0; b < BANK_NUM; b++) begin
      rd_mux_s = rd_mux_s | (bank_rd_s[b] & {PDATA_WIDTH{rd_sel_s == bank_code(unsigned'(b))}});
    end
  end

  // Only read frames put register data on miso
  always_comb begin
    rd_word_s = 8'h00;
    if (!rx_shift_r[7]) begin
      rd_word_s = rd_mux_s;
    end else begin
      rd_word_s = 8'h00;
    end
  end

  // Tx shifter on falling sclk: load after bit 8, then shift out MSB first
  always_ff @(negedge sclk or negedge resetn or posedge ss) begin
    if (!resetn) begin
      tx_shift_r <= 8'h00;
    end else if (ss) begin
      tx_shift_r <= 8'h00;
    end else if (bit_cnt_r == 5'd8) begin
      tx_shift_r <= rd_word_s;
    end else if (bit_cnt_r > 5'd8) begin
      tx_shift_r <= {tx_shift_r[PDATA_WIDTH-2:0], 1'b0};
    end else begin
      tx_shift_r <= tx_shift_r;
    end
  end

  assign miso = tx_shift_r[PDATA_WIDTH-1];

  for (genvar b = 0; b < BANK_NUM; b++) begin : g_bank
    assign bank_wr_s[b] = wr_commit_s && (wr_sel_s == bank_code(unsigned'(b)));

    gpio_bank u_bank (
      .clk     (sclk),
      .rst_n   (resetn),
      .wr_en   (bank_wr_s[b]),
      .wr_idx  (wr_idx_s),
      .wr_data (wr_data_s),
      .rd_idx  (rd_idx_s),
      .rd_data (bank_rd_s[b]),
      .pad     (pad[PDATA_WIDTH*b +: PDATA_WIDTH])
    );
  end

endmodule

// File: tb/tb_gpio_expander.sv
// Directed bench for gpio_expander: vector table of SPI transactions plus
// hand-written sequences for aborted frames, extra edges, reset and bursts.
module tb_gpio_expander;

  logic        sclk;
  logic        resetn;
  logic        ss;
  logic        mosi;
  logic        miso;
  wire  [15:0] pad;
  logic [15:0] tb_drv;
  logic [15:0] tb_en;

  int n_cmp;
  int n_fail;

  gpio_expander dut (
    .sclk   (sclk),
    .resetn (resetn),
    .ss     (ss),
    .mosi   (mosi),
    .miso   (miso),
    .pad    (pad)
  );

  for (genvar i = 0; i < 16; i++) begin : g_drv
    assign pad[i] = tb_en[i] ? tb_drv[i] : 1'bz;
  end

  typedef struct {
    logic       w;
    logic [6:0] addr;
    logic [7:0] data;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One SPI frame of nbits clocks; bits beyond 16 send mosi=1
  task automatic spi_frame(input logic w, input logic [6:0] addr, input logic [7:0] data,
                           input int nbits, output logic [7:0] rdata, output logic hi_zero);
    logic [15:0] frame;
    frame   = {w, addr, data};
    rdata   = 8'h00;
    hi_zero = 1'b1;
    ss = 1'b0;
    #5;
    for (int i = 0; i < nbits; i++) begin
      mosi = (i < 16) ? frame[15-i] : 1'b1;
      #2;
      if (i >= 8 && i < 16) rdata[15-i] = miso;
      else if (i < 8 && miso !== 1'b0) hi_zero = 1'b0;
      #3 sclk = 1'b1;
      #5 sclk = 1'b0;
    end
    #5 ss = 1'b1;
    mosi = 1'b0;
    #10;
  endtask

  task automatic spi_write(input logic [6:0] addr, input logic [7:0] data);
    logic [7:0] r;
    logic       h;
    spi_frame(1'b1, addr, data, 16, r, h);
  endtask

  task automatic spi_read_check(input string name, input logic [6:0] addr, input logic [7:0] exp);
    logic [7:0] r;
    logic       h;
    spi_frame(1'b0, addr, 8'h00, 16, r, h);
    check(name, {8'h00, r}, {8'h00, exp});
    check({name, "_hi_zero"}, {15'h0, h}, 16'h0001);
  endtask

  initial begin
    logic [7:0] r;
    logic       h;
    logic [7:0] acc;
    n_cmp  = 0;
    n_fail = 0;
    sclk   = 1'b0;
    ss     = 1'b1;
    mosi   = 1'b0;
    resetn = 1'b0;
    tb_drv = 16'h0000;
    tb_en  = 16'h0000;
    #20 resetn = 1'b1;
    #10;

    // Reset state
    check("reset_miso", {15'h0, miso}, 16'h0000);
    spi_read_check("reset_dir0", 7'h20, 8'h00);
    spi_read_check("reset_out0", 7'h24, 8'h00);
    // All pads undriven: bench values must come back through IN
    tb_drv = 16'h5A3C;
    tb_en  = 16'hFFFF;
    #5;
    spi_read_check("reset_hiz_in0", 7'h28, 8'h3C);
    spi_read_check("reset_hiz_in1", 7'h48, 8'h5A);
    check("ss_high_miso", {15'h0, miso}, 16'h0000);

    // Bench only drives bank1 pins 11:8 from here on
    tb_drv = 16'h0900;
    tb_en  = 16'h0F00;

    vecs.push_back('{1'b1, 7'h24, 8'hA5, 8'h00});
    vecs.push_back('{1'b1, 7'h20, 8'hFF, 8'h00});
    vecs.push_back('{1'b0, 7'h28, 8'h00, 8'hA5});
    vecs.push_back('{1'b1, 7'h44, 8'h3C, 8'h00});
    vecs.push_back('{1'b1, 7'h40, 8'hF0, 8'h00});
    vecs.push_back('{1'b0, 7'h48, 8'h00, 8'h39});
    vecs.push_back('{1'b1, 7'h38, 8'hFF, 8'h00});
    vecs.push_back('{1'b0, 7'h24, 8'h00, 8'h5A});
    vecs.push_back('{1'b1, 7'h2C, 8'h01, 8'h00});
    vecs.push_back('{1'b0, 7'h24, 8'h00, 8'h5B});
    vecs.push_back('{1'b1, 7'h30, 8'h50, 8'h00});
    vecs.push_back('{1'b0, 7'h24, 8'h00, 8'h0B});
    vecs.push_back('{1'b0, 7'h20, 8'h00, 8'hFF});
    vecs.push_back('{1'b0, 7'h40, 8'h00, 8'hF0});
    vecs.push_back('{1'b0, 7'h44, 8'h00, 8'h3C});
    vecs.push_back('{1'b1, 7'h60, 8'hFF, 8'h00});
    vecs.push_back('{1'b1, 7'h00, 8'hFF, 8'h00});
    vecs.push_back('{1'b0, 7'h60, 8'h00, 8'h00});
    vecs.push_back('{1'b0, 7'h2C, 8'h00, 8'h00});
    vecs.push_back('{1'b0, 7'h34, 8'h00, 8'h00});
    vecs.push_back('{1'b1, 7'h28, 8'hFF, 8'h00});
    vecs.push_back('{1'b1, 7'h34, 8'hFF, 8'h00});
    vecs.push_back('{1'b1, 7'h3C, 8'hFF, 8'h00});
    vecs.push_back('{1'b0, 7'h24, 8'h00, 8'h0B});
    vecs.push_back('{1'b0, 7'h20, 8'h00, 8'hFF});
    vecs.push_back('{1'b0, 7'h44, 8'h00, 8'h3C});
    vecs.push_back('{1'b0, 7'h27, 8'h00, 8'h0B});
    vecs.push_back('{1'b0, 7'h28, 8'h00, 8'h0B});

    foreach (vecs[k]) begin
      spi_frame(vecs[k].w, vecs[k].addr, vecs[k].data, 16, r, h);
      if (!vecs[k].w) begin
        check($sformatf("vec%0d_rd_%02h", k, vecs[k].addr), {8'h00, r}, {8'h00, vecs[k].exp});
        check($sformatf("vec%0d_hi_zero", k), {15'h0, h}, 16'h0001);
      end
      if (k == 1) check("pad_bank0_a5", {8'h00, pad[7:0]}, 16'h00A5);
      if (k == 4) check("pad_bank1_hi", {12'h000, pad[15:12]}, 16'h0003);
    end
    check("pad_bank0_final", {8'h00, pad[7:0]}, 16'h000B);

    // Aborted write: ss rises after 10 bits
    spi_frame(1'b1, 7'h24, 8'hFF, 10, r, h);
    spi_read_check("abort_out0", 7'h24, 8'h0B);

    // Edges after the 16th bit are ignored
    spi_frame(1'b1, 7'h44, 8'h81, 20, r, h);
    spi_read_check("extra_edges_out1", 7'h44, 8'h81);
    check("pad_bank1_81", {12'h000, pad[15:12]}, 16'h0008);

    // resetn mid-frame clears everything
    ss = 1'b0;
    #5;
    for (int i = 0; i < 6; i++) begin
      mosi = i[0];
      #5 sclk = 1'b1;
      #5 sclk = 1'b0;
    end
    resetn = 1'b0;
    #10 resetn = 1'b1;
    ss = 1'b1;
    #10;
    spi_read_check("midreset_dir0", 7'h20, 8'h00);
    spi_read_check("midreset_out1", 7'h44, 8'h00);
    spi_read_check("midreset_dir1", 7'h40, 8'h00);

    // Back-to-back toggles on bank0 OUT
    acc = 8'h00;
    for (int i = 0; i < 256; i++) begin
      spi_write(7'h38, 8'(i));
      acc = acc ^ 8'(i);
      if (i == 5) spi_read_check("burst_mid", 7'h24, acc);
    end
    spi_read_check("burst_final", 7'h24, acc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/gpio_expander.md
Name: gpio_expander

Overview:
SPI-slave-controlled 16-bit GPIO expander with two banks of 8 bidirectional pads. A 16-bit SPI frame carries a read/write flag, a 7-bit register address and 8 data bits. The frame is decoded into a simple register bus to per-bank direction, output and input registers. The block sits at chip top, between an external SPI master and the physical pads.

Parameters:
BANK_NUM, 2, number of 8-pin GPIO banks
DATA_WIDTH, 16, SPI frame length in bits
PDATA_WIDTH, 8, register data width (pins per bank)
ADDR_WIDTH, 7, SPI address field width
PADDR_WIDTH, 3, per-bank register index width

Ports:
sclk  input  1  SPI clock; the only clock (mode 0)
resetn  input  1  asynchronous active-low reset
ss  input  1  SPI slave select, active low
mosi  input  1  serial data in, MSB first
miso  output  1  serial data out, MSB first
pad  inout  16  GPIO pads; pad[8b+7:8b] belong to bank b

Behaviour:
- Single clock sclk. Reset is asynchronous, active-low (resetn).
- Reset values: all DIR=0 (pads high-Z), all OUT=0, miso=0, bit counter=0, frame shift register=0.
- Frame format, bit 15 first: bit15 = W (1 write, 0 read); bits14:8 = addr; bits7:0 = data.
- mosi is sampled on rising sclk while ss=0. miso changes on falling sclk.
- ss=1 asynchronously clears the bit counter and receive shifter. It does not clear GPIO registers. miso=0 while ss=1.
- Partial frame (ss rises before the 16th rising edge): discarded, no register change.
- Write commits on the 16th rising sclk edge of the frame. The register updates at that edge.
- After 16 bits, further sclk edges are ignored until ss deasserts.
- Read: on the falling edge after the 8th rising edge, the addressed register value is loaded into the tx shifter. It is shifted out on miso during frame bits 7..0. miso=0 during bits 15..8.
- Address decode: addr[6:5]=01 selects bank0, 10 selects bank1; 00/11 unmapped. Register index = addr[4:2]; addr[1:0] ignored.
- Register indices:
  - 0 DIR (rw): 1 = output.
  - 1 OUT (rw).
  - 2 IN (ro): current pad levels.
  - 3 SET (wo): OUT |= data.
  - 4 CLR (wo): OUT &= ~data.
  - 6 TGL (wo): OUT ^= data.
  - 5, 7 reserved.
- Reads of wo/reserved/unmapped registers return 0x00. Writes to ro/reserved/unmapped registers are ignored.
- Pad drive: pad[i] = OUT bit when DIR bit is 1, else high-Z.
- IN reads the pad value at the load edge, with no synchronizer. An output pad reads back its driven value.
- Bank 0 byte addresses: DIR 0x20, OUT 0x24, IN 0x28, SET 0x2C, CLR 0x30, TGL 0x38.
- Bank 1 byte addresses: DIR 0x40, OUT 0x44, IN 0x48, SET 0x4C, CLR 0x50, TGL 0x58.
- resetn low mid-frame aborts the frame and resets all state.

Decomposition:
- Package gpio_expander_pkg holds:
  - frame field positions (W bit, addr, data);
  - register index constants DIR/OUT/IN/SET/CLR/TGL;
  - bank select codes;
  - width constants.
- One sub-module gpio_bank, instantiated BANK_NUM times. It holds the DIR/OUT registers, the SET/CLR/TGL update logic, read mux and pad tristate.
- SPI shifter, counter and address decode stay in gpio_expander.

Test Plan:
- Reset: pulse resetn low, then read 0x20 and 0x24 -> miso returns 0x00 both times; pad = all Z.
- Bank0 output: write 0x24=0xA5, then 0x20=0xFF -> pad[7:0]=0xA5, pad[15:8]=Z; read 0x28 -> 0xA5.
- Bank1 partial output:
  - Write 0x44=0x3C, then 0x40=0xF0 -> pad[15:12]=0x3, pad[11:8]=Z.
  - Bench drives pad[11:8]=0x9 -> read 0x48 returns 0x39.
- Bit ops on bank0 OUT=0xA5:
  - write 0x38=0xFF -> OUT=0x5A;
  - write 0x2C=0x01 -> 0x5B;
  - write 0x30=0x50 -> 0x0B;
  - read 0x24 -> 0x0B.
- Aborted/unmapped:
  - Raise ss after 10 bits of a write to 0x24 -> OUT unchanged.
  - Write 0x60=0xFF -> no change.
  - Read 0x60 -> 0x00.
- Back-to-back: 256 consecutive writes of incrementing data to 0x38, ss high ≥1 sclk-equivalent between frames -> final OUT equals XOR of all data (0x00 from 0).
